// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared definitions for the seven-segment display path.
//                Active-low blank pattern, hex-to-segment lookup table and
//                the per-slot scan state type.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed table indexed directly by the hex nibble (entry 0 is the LSBs).
    localparam logic [15:0][6:0] HEX7SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg
//  Description : Combinational hex digit to active-low seven-segment decoder.
//  Ports       : hex_i  [3:0]  hex digit
//                seg_o  [6:0]  segments {g,f,e,d,c,b,a}, active low
//  Revision    : 1.0  initial release
// ============================================================================
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7SEG_TABLE[hex_i];

endmodule : hex7seg
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexes a 16-bit value (4 hex digits) onto a
//                4-digit seven-segment display. Each digit slot begins with a
//                blanking gap; new data is taken over a valid/ready handshake
//                into a pending register and copied to the display register
//                only at frame boundaries.
//  Ports       : clk_i          system clock
//                rst_n_i        asynchronous reset, active low
//                data_in_i[15:0] digits; [3:0] = digit 0 ... [15:12] = digit 3
//                data_valid_i   data_in_i valid this cycle
//                data_ready_o   pending register empty
//                digit_en_i[3:0] per-digit enable, sampled live
//                seg_o[6:0]     segments {g,f,e,d,c,b,a}, active low
//                comm_o[3:0]    digit anodes, one-hot or zero, active high
//                frame_tick_o   pulse on the first cycle of the digit-0 slot
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] data_in_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    input  logic [3:0]  digit_en_i,
    output logic [6:0]  seg_o,
    output logic [3:0]  comm_o,
    output logic        frame_tick_o
);

    localparam int            DIV       = CLK_HZ / SCAN_HZ;
    localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q,          cnt_d;
    logic [1:0]    idx_q,          idx_d;
    scan_state_t   state_q,        state_d;
    logic [15:0]   pending_q,      pending_d;
    logic          pending_full_q, pending_full_d;
    logic [15:0]   display_q,      display_d;
    logic [6:0]    seg_q,          seg_d;
    logic [3:0]    comm_q,         comm_d;
    logic          ready_q;
    logic          tick_q;

    logic          slot_wrap;
    logic          frame_wrap;
    logic          accept;
    logic          drive_en;
    logic [3:0]    nibble;
    logic [6:0]    nibble_seg;

    hex7seg u_hex7seg (
        .hex_i (nibble),
        .seg_o (nibble_seg)
    );

    // Outputs are registered from the next-state values, so every output
    // register always describes the slot position held in cnt_q/idx_q.
    always_comb begin
        slot_wrap  = (cnt_q == CNT_LAST);
        frame_wrap = slot_wrap && (idx_q == 2'd3);
        accept     = data_valid_i && ready_q;

        cnt_d = slot_wrap ? '0 : cnt_q + CW'(1);
        idx_d = slot_wrap ? idx_q + 2'd1 : idx_q;

        // Reaching the blank length enters DRIVE; a slot wrap restarts BLANK.
        // Testing the DRIVE entry first keeps a zero-length gap working.
        if (cnt_d == CNT_BLANK) begin
            state_d = DRIVE;
        end else if (slot_wrap) begin
            state_d = BLANK;
        end else begin
            state_d = state_q;
        end

        // A full pending register cannot accept, so the boundary transfer
        // and a new accept never collide on the same edge.
        display_d      = display_q;
        pending_full_d = pending_full_q;
        if (frame_wrap && pending_full_q) begin
            display_d      = pending_q;
            pending_full_d = 1'b0;
        end else if (accept) begin
            pending_full_d = 1'b1;
        end
        pending_d = accept ? data_in_i : pending_q;

        nibble   = display_d[{idx_d, 2'b00} +: 4];
        drive_en = (state_d == DRIVE) && digit_en_i[idx_d];
        comm_d   = drive_en ? (4'b0001 << idx_d) : 4'b0000;
        seg_d    = drive_en ? nibble_seg : SEG_BLANK;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q          <= '0;
            idx_q          <= 2'd0;
            state_q        <= BLANK;
            pending_q      <= 16'h0000;
            pending_full_q <= 1'b0;
            display_q      <= 16'h0000;
            seg_q          <= SEG_BLANK;
            comm_q         <= 4'h0;
            ready_q        <= 1'b1;
            tick_q         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            state_q        <= state_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            display_q      <= display_d;
            seg_q          <= seg_d;
            comm_q         <= comm_d;
            ready_q        <= ~pending_full_d;
            tick_q         <= frame_wrap;
        end
    end

    assign seg_o        = seg_q;
    assign comm_o       = comm_q;
    assign data_ready_o = ready_q;
    assign frame_tick_o = tick_q;

endmodule : seg_scan_driver
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver (DIV=10, blank=2).
//                A frame-level reference model predicts every output on
//                every cycle from elapsed time, the shown value and the
//                pending slot.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  digit_en = 4'hF;
    logic [6:0]  seg;
    logic [3:0]  comm;
    logic        tick;

    int tests = 0;
    int fails = 0;

    // Reference model state: cycles since reset release, shown value,
    // pending slot, enables seen at the last edge, accept at the last edge.
    int          m_t    = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    bit          m_full = 1'b0;
    logic [3:0]  m_en   = 4'hF;
    bit          m_acc  = 1'b0;

    seg_scan_driver #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .data_in_i    (data),
        .data_valid_i (valid),
        .data_ready_o (ready),
        .digit_en_i   (digit_en),
        .seg_o        (seg),
        .comm_o       (comm),
        .frame_tick_o (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s at t=%0d: observed %h expected %h", tag, m_t, got, exp);
        end
    endtask

    // Compare all outputs against what the model says this cycle should show.
    task automatic check_model();
        int          pos;
        int          dig;
        bit          on;
        logic [3:0]  e_comm;
        logic [6:0]  e_seg;
        pos    = m_t % 10;
        dig    = (m_t / 10) % 4;
        on     = (pos >= 2) && m_en[dig];
        e_comm = on ? (4'b0001 << dig) : 4'b0000;
        e_seg  = on ? ref_seg(m_disp[dig*4 +: 4]) : 7'h7F;
        chk("comm",  {28'h0, comm},  {28'h0, e_comm});
        chk("seg",   {25'h0, seg},   {25'h0, e_seg});
        chk("ready", {31'h0, ready}, {31'h0, ~m_full});
        chk("tick",  {31'h0, tick},  {31'h0, (m_t > 0) && (m_t % 40 == 0)});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg"},   {25'h0, seg},   32'h7F);
        chk({tag, "_comm"},  {28'h0, comm},  32'h0);
        chk({tag, "_ready"}, {31'h0, ready}, 32'h1);
        chk({tag, "_tick"},  {31'h0, tick},  32'h0);
    endtask

    // One clock: advance the model across the edge, then check outputs.
    task automatic cycle();
        @(posedge clk);
        m_acc = valid && !m_full;
        if ((m_t % 40 == 39) && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end
        if (m_acc) begin
            m_pend = data;
            m_full = 1'b1;
        end
        m_en = digit_en;
        m_t++;
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic send(input logic [15:0] v);
        bit done;
        done  = 1'b0;
        data  = v;
        valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            cycle();
            done = m_acc;
        end
        valid = 1'b0;
        if (!done) chk("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_tick();
        int guard;
        guard = 0;
        do begin
            cycle();
            guard++;
        end while ((m_t % 40 != 0) && guard < 60);
        if (guard >= 60) chk("tick_timeout", 32'h0, 32'h1);
    endtask

    task automatic run_to_pos(input int p);
        int guard;
        guard = 0;
        while ((m_t % 40 != p) && guard < 60) begin
            cycle();
            guard++;
        end
        if (guard >= 60) chk("pos_timeout", 32'h0, 32'h1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        m_t    = 0;
        m_disp = 16'h0000;
        m_full = 1'b0;
        m_acc  = 1'b0;
        #1;
        check_model();
    endtask

    initial begin
        int guard;

        // 1. Reset values while held, then scan timing after release.
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst_hold");
        end
        release_reset();

        // 2. Load 1234 at cycle 5; first tick exactly 40 cycles after release.
        run(5);
        data  = 16'h1234;
        valid = 1'b1;
        cycle();
        valid = 1'b0;
        chk("load_ready_low", {31'h0, ready}, 32'h0);
        guard = 0;
        while (!tick && guard < 60) begin
            cycle();
            guard++;
        end
        chk("first_tick_t", m_t, 32'd40);
        chk("ready_after_bnd", {31'h0, ready}, 32'h1);
        run(2);
        chk("d0_4_comm", {28'h0, comm}, 32'h1);
        chk("d0_4_seg",  {25'h0, seg},  {25'h0, 7'b0011001});
        run(10);
        chk("d1_3_seg",  {25'h0, seg},  {25'h0, 7'b0110000});
        run(10);
        chk("d2_2_seg",  {25'h0, seg},  {25'h0, 7'b0100100});
        run(10);
        chk("d3_1_comm", {28'h0, comm}, 32'h8);
        chk("d3_1_seg",  {25'h0, seg},  {25'h0, 7'b1111001});

        // 3. Backpressure: second value stalls until a boundary frees pending.
        send(16'hAAAA);
        send(16'hFFFF);
        run(90);

        // 4. Digits 1 and 3 disabled.
        digit_en = 4'b0101;
        send(16'h0000);
        run(90);

        // 5. Accept on the exact tick cycle: display waits one more frame.
        digit_en = 4'hF;
        wait_tick();
        chk("bnd_ready", {31'h0, ready}, 32'h1);
        data  = 16'h5555;
        valid = 1'b1;
        cycle();
        valid = 1'b0;
        run(2);
        chk("bnd_old_seg", {25'h0, seg}, {25'h0, 7'b1000000});
        run(40);
        chk("bnd_new_seg", {25'h0, seg}, {25'h0, 7'b0010010});

        // Randomized traffic with live enable changes.
        for (int i = 0; i < 400; i++) begin
            if (!valid || m_acc) begin
                valid = ($urandom_range(0, 3) == 0);
                data  = 16'($urandom);
            end
            if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom);
            cycle();
        end
        valid    = 1'b0;
        digit_en = 4'hF;
        run(45);

        // 6. Asynchronous reset mid-DRIVE of digit 2 with pending full.
        wait_tick();
        send(16'h9999);
        run_to_pos(25);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold2");
        release_reset();
        run(42);
        chk("post_rst_d0", {25'h0, seg}, {25'h0, 7'b1000000});
        run(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_seg_scan_driver
`default_nettype wire
